// File: rtl/some_package.sv
// Shared definitions for the sample accumulator.
// Readback and debug logic decode the accumulator state through this enum.
package some_package;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/sample_accumulator.sv
// Sums a fixed window of valid samples and tracks the window maximum.
// The result is presented on a valid/ready handshake.
module sample_accumulator
    import some_package::*;
#(
    parameter  int DATA_W = 20,
    parameter  int WINDOW = 8,
    localparam int SUM_W  = DATA_W + $clog2(WINDOW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    output logic              busy,
    output logic              overrun
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    acc_state_t        state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overrun_q, overrun_d;
    logic              clr_pend_q, clr_pend_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sum_q      <= '0;
            max_q      <= '0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
            clr_pend_q <= clr_pend_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    // A start taken together with the handshake clears overrun one cycle
    // late, so the consumer still sees the previous window's drop flag.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        max_d      = max_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        clr_pend_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ACCUM;
                    sum_d     = '0;
                    max_d     = '0;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            ST_ACCUM: begin
                if (clr_pend_q) begin
                    overrun_d = 1'b0;
                end
                if (in_valid) begin
                    sum_d = sum_q + SUM_W'(in_data);
                    max_d = (in_data > max_q) ? in_data : max_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready && start) begin
                    state_d    = ST_ACCUM;
                    sum_d      = '0;
                    max_d      = '0;
                    cnt_d      = '0;
                    clr_pend_d = 1'b1;
                end else begin
                    if (in_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_HOLD);
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_max   = max_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule
